// File: rtl/serial_transmitter.sv
// serial_transmitter: framed LSB-first serial line driver.
// Each frame is a start bit (0), WIDTH data bits, an optional even-parity bit
// and a stop bit (1). Every bit is held for HOLDCYCLES clocks, so a remote
// synchroniser/debouncer sees each level for long enough to capture it.
// Optional feature: define SERIAL_TRANSMITTER_PARITY_EN to insert the parity
// bit between the last data bit and the stop bit.
// All outputs are registered; the line idles high.
module serial_transmitter #(
    parameter int WIDTH      = 8,
    parameter int HOLDCYCLES = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] parallelin,
    input  logic             loaddata,
    output logic             ready,
    output logic             serialout,
    output logic             busy,
    output logic             framedone
);

    localparam int HW = $clog2(HOLDCYCLES);
    localparam int BW = $clog2(WIDTH) + 1;

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDCYCLES - 1);
    localparam logic [BW-1:0] BITS_LAST = BW'(WIDTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef SERIAL_TRANSMITTER_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t           state;
    logic [HW-1:0]    holdcnt;
    logic [BW-1:0]    bitcnt;
    logic [WIDTH-1:0] shreg;
`ifdef SERIAL_TRANSMITTER_PARITY_EN
    logic             paritybit;
`endif
    logic             hold_end;

    // The current bit has been on the line for its full hold time.
    assign hold_end = (holdcnt == HOLD_LAST);

    // Frame sequencer: state, counters, shift register and all registered outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            holdcnt   <= '0;
            bitcnt    <= '0;
            serialout <= 1'b1;
            ready     <= 1'b1;
            busy      <= 1'b0;
            framedone <= 1'b0;
        end else begin
            // framedone is a single-cycle pulse; only the STOP exit raises it.
            framedone <= 1'b0;
            case (state)
                IDLE: begin
                    if (loaddata && ready) begin
                        shreg     <= parallelin;
`ifdef SERIAL_TRANSMITTER_PARITY_EN
                        paritybit <= ^parallelin;
`endif
                        state     <= START;
                        holdcnt   <= '0;
                        bitcnt    <= '0;
                        serialout <= 1'b0;
                        ready     <= 1'b0;
                        busy      <= 1'b1;
                    end
                end

                START: begin
                    if (hold_end) begin
                        holdcnt   <= '0;
                        state     <= DATA;
                        serialout <= shreg[0];
                        shreg     <= shreg >> 1;
                        bitcnt    <= BW'(1);
                    end else begin
                        holdcnt <= holdcnt + HW'(1);
                    end
                end

                DATA: begin
                    if (hold_end) begin
                        holdcnt <= '0;
                        // bitcnt counts bits already placed on the line.
                        if (bitcnt == BITS_LAST) begin
`ifdef SERIAL_TRANSMITTER_PARITY_EN
                            state     <= PARITY;
                            serialout <= paritybit;
`else
                            state     <= STOP;
                            serialout <= 1'b1;
`endif
                        end else begin
                            serialout <= shreg[0];
                            shreg     <= shreg >> 1;
                            bitcnt    <= bitcnt + BW'(1);
                        end
                    end else begin
                        holdcnt <= holdcnt + HW'(1);
                    end
                end

`ifdef SERIAL_TRANSMITTER_PARITY_EN
                PARITY: begin
                    if (hold_end) begin
                        holdcnt   <= '0;
                        state     <= STOP;
                        serialout <= 1'b1;
                    end else begin
                        holdcnt <= holdcnt + HW'(1);
                    end
                end
`endif

                STOP: begin
                    if (hold_end) begin
                        // Ready rises with framedone so a load in this cycle
                        // starts the next frame back-to-back.
                        holdcnt   <= '0;
                        bitcnt    <= '0;
                        state     <= IDLE;
                        serialout <= 1'b1;
                        ready     <= 1'b1;
                        busy      <= 1'b0;
                        framedone <= 1'b1;
                    end else begin
                        holdcnt <= holdcnt + HW'(1);
                    end
                end

                default: begin
                    state     <= IDLE;
                    holdcnt   <= '0;
                    bitcnt    <= '0;
                    serialout <= 1'b1;
                    ready     <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_transmitter.sv
// tb_serial_transmitter: scoreboard bench for serial_transmitter.
// A posedge model decides which loads are accepted and queues the expected
// frames; a negedge monitor compares every cycle of outputs against the
// frame waveform derived from the queued word.
module tb_serial_transmitter;

    localparam int W = 8;
    localparam int H = 4;
`ifdef SERIAL_TRANSMITTER_PARITY_EN
    localparam int NB = W + 3;
`else
    localparam int NB = W + 2;
`endif
    localparam int FL = NB * H;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         loaddata = 1'b0;
    logic [W-1:0] parallelin = '0;
    logic         ready;
    logic         serialout;
    logic         busy;
    logic         framedone;

    serial_transmitter #(.WIDTH(W), .HOLDCYCLES(H)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .parallelin(parallelin),
        .loaddata  (loaddata),
        .ready     (ready),
        .serialout (serialout),
        .busy      (busy),
        .framedone (framedone)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        int           e0;
    } frame_t;

    frame_t sb_q[$];
    frame_t cur;
    bit     active = 1'b0;
    int     edge_n = 0;
    bit     rst_last = 1'b0;
    int     model_free = 0;
    int     acc = 0;
    int     n_checks = 0;
    int     n_fails = 0;

    // Line level of bit slot k of a frame carrying word d.
    function automatic logic line_bit(logic [W-1:0] d, int k);
        if (k == 0) return 1'b0;
        if (k <= W) return d[k-1];
        if (NB == W + 3 && k == W + 1) return ^d;
        return 1'b1;
    endfunction

    task automatic check(string name, logic [3:0] act, logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s edge=%0d got {serialout,ready,busy,framedone}=%b expected %b",
                     name, edge_n, act, exp);
        end
    endtask

    // Reference model: acceptance decided from frame length alone.
    initial forever begin
        @(posedge clk);
        edge_n++;
        if (!resetn) begin
            rst_last   = 1'b1;
            model_free = 0;
            sb_q.delete();
        end else begin
            rst_last = 1'b0;
            if (loaddata && edge_n >= model_free) begin
                frame_t f;
                f.data = parallelin;
                f.e0   = edge_n;
                sb_q.push_back(f);
                model_free = edge_n + FL + 1;
                acc++;
            end
        end
    end

    // Monitor: compare all outputs once per cycle, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (edge_n > 0) begin
            if (rst_last) begin
                active = 1'b0;
                check("reset", {serialout, ready, busy, framedone}, 4'b1100);
            end else begin
                if (!active && sb_q.size() > 0 && sb_q[0].e0 == edge_n) begin
                    cur    = sb_q.pop_front();
                    active = 1'b1;
                end
                if (active) begin
                    int k;
                    k = edge_n - cur.e0;
                    if (k < FL) begin
                        check("frame", {serialout, ready, busy, framedone},
                              {line_bit(cur.data, k / H), 3'b010});
                    end else begin
                        check("framedone", {serialout, ready, busy, framedone}, 4'b1101);
                        active = 1'b0;
                    end
                end else begin
                    check("idle", {serialout, ready, busy, framedone}, 4'b1100);
                end
            end
        end
    end

    task automatic idle(int n);
        loaddata = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(logic [W-1:0] d);
        parallelin = d;
        loaddata   = 1'b1;
        @(negedge clk);
        loaddata   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int a0;
        // Reset held with a pending load: nothing may start.
        resetn     = 1'b0;
        loaddata   = 1'b1;
        parallelin = 8'hFF;
        repeat (3) @(negedge clk);
        resetn   = 1'b1;
        loaddata = 1'b0;
        idle(3);

        // Basic frames, including parity-sensitive words.
        send(8'hA5);
        idle(FL + 5);
        send(8'h07);
        idle(FL + 5);

        // Load pulse while busy is ignored.
        send(8'hFF);
        idle(9);
        parallelin = 8'h00;
        loaddata   = 1'b1;
        @(negedge clk);
        idle(FL);

        // Back-to-back frames with loaddata held high.
        a0         = acc;
        parallelin = 8'h3C;
        loaddata   = 1'b1;
        for (int t = 0; t < 4 * FL && acc == a0; t++) @(negedge clk);
        parallelin = 8'hC3;
        for (int t = 0; t < 4 * FL && acc == a0 + 1; t++) @(negedge clk);
        loaddata = 1'b0;
        n_checks++;
        if (acc != a0 + 2) begin
            n_fails++;
            $display("FAIL b2b_accepts got %0d expected %0d", acc - a0, 2);
        end
        idle(FL + 5);

        // Reset in the middle of a frame, then a full clean frame.
        send(8'h5A);
        idle(16);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        idle(5);
        send(8'h96);
        idle(FL + 5);

        // Randomised loads with occasional resets.
        for (int i = 0; i < 600; i++) begin
            int r;
            r          = $urandom_range(0, 99);
            resetn     = (r >= 2);
            loaddata   = (r >= 2 && r < 30);
            parallelin = W'($urandom);
            @(negedge clk);
        end
        resetn = 1'b1;
        idle(FL + 5);

        // Every queued frame must have been fully observed.
        n_checks++;
        if (sb_q.size() != 0 || active) begin
            n_fails++;
            $display("FAIL drain got queue=%0d active=%0d expected 0 0", sb_q.size(), active);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/serial_transmitter.md
# serial_transmitter

Framed serial transmitter that drives a single line hard enough for a remote `inputconditioner` to capture it cleanly. Each bit is held for a programmable number of clock cycles, at least the receiver's synchroniser plus debounce wait. A parallel word is accepted through a load/ready handshake and shifted out LSB-first between a start bit and a stop bit. The block sits at the output edge of the design, opposite the input conditioner on the receiving end.

## Interface
- `WIDTH`, 8: data bits per frame (1–32).
- `HOLDCYCLES`, 8: clock cycles each bit is held on the line (≥2).
- `clk`  input  1  system clock; all logic on rising edge.
- `resetn`  input  1  synchronous active-low reset.
- `parallelin`  input  WIDTH  word to transmit; sampled only on an accepted load.
- `loaddata`  input  1  load request.
- `ready`  output  1  high when a load will be accepted this cycle.
- `serialout`  output  1  serial line, registered; idles high.
- `busy`  output  1  high while a frame is on the line.
- `framedone`  output  1  one-cycle pulse when a frame completes.

## Operation
- Reset values, with `resetn` low at an edge: `serialout`=1, `ready`=1, `busy`=0, `framedone`=0. State is IDLE and all counters are 0.
- Accept: `loaddata` && `ready` at an edge. On accept, `parallelin` is latched into the shift register.
- `loaddata` while not ready is ignored, with no queuing.
- States and their `serialout` value:
  - IDLE: `serialout`=1.
  - START: `serialout`=0.
  - DATA: `serialout`=shreg[0]; the register shifts right once per bit.
  - PARITY: only when configured in (see Configuration).
  - STOP: `serialout`=1.
- Transitions:
  - IDLE → START on accept.
  - START → DATA.
  - DATA → DATA until WIDTH bits are sent, then → PARITY or STOP.
  - PARITY → STOP.
  - STOP → IDLE.
  - Every state except IDLE lasts exactly HOLDCYCLES cycles.
- Counters:
  - Hold counter: width $clog2(HOLDCYCLES), counts 0..HOLDCYCLES-1 and wraps to 0 on each state or bit advance.
  - Bit counter: width $clog2(WIDTH)+1.
- `busy` = state ≠ IDLE. `ready` = state == IDLE.
- `framedone` is high exactly during the first IDLE cycle after STOP. `ready` is also 1 in that cycle, so a load in that cycle is accepted (back-to-back frames).
- Reset mid-frame: at the next edge with `resetn` low, `serialout`=1 and the frame is discarded. No `framedone` is generated.

## Timing
- Accept at edge E0. `serialout` falls at E0 and stays 0 through edge E0+HOLDCYCLES.
- Data bit i is driven from E0+(1+i)·HOLDCYCLES for HOLDCYCLES cycles.
- Line-busy length: (WIDTH+2)·HOLDCYCLES cycles, or (WIDTH+3)·HOLDCYCLES with parity.
- `framedone` pulses at E0 + frame length. `ready` rises on the same edge.
- Minimum line-high between frames is HOLDCYCLES+1 cycles: the stop bit plus one IDLE cycle.
- All outputs are registered; none combinationally depends on inputs.

## Configuration
- Macro: `SERIAL_TRANSMITTER_PARITY_EN`.
- Defined: PARITY state inserted between DATA and STOP.
  - Drives the even-parity bit (XOR of the latched word) for HOLDCYCLES cycles.
  - The frame grows by HOLDCYCLES cycles.
- Undefined: no PARITY state and no parity logic; DATA → STOP directly.

## Test plan
Settings for all scenarios: WIDTH=8, HOLDCYCLES=4.
- **Reset:** hold `resetn`=0 for 3 cycles with `loaddata`=1 → `serialout`=1, `ready`=1, `busy`=0, `framedone`=0 throughout; no frame starts.
- **Basic frame:** load 8'hA5 → `serialout` is 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles. `framedone` pulses at cycle 40 after accept.
- **Parity (macro defined):** load 8'hA5 → parity bit 0 for 4 cycles after bit 7; `framedone` at cycle 44.
  - Load 8'h07 → parity bit 1.
- **Busy-load rejection:** load 8'hFF, then pulse `loaddata` with 8'h00 at cycle 10 → the line still carries 8'hFF; `ready` stays 0 until `framedone`.
- **Back-to-back:** hold `loaddata`=1 with 8'h3C then 8'hC3 → the second start bit begins on the edge after `framedone`; the line stays high for exactly 5 cycles between frames.
- **Mid-frame reset:** assert `resetn`=0 for 1 cycle at cycle 17 of a frame → `serialout`=1 on the next edge, no `framedone`, `ready`=1. A new load then sends a full, correct frame.
